// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_NOT  = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD = 2'b11;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/alu_arb_pick.sv
// 2-way request picker: round-robin by default, fixed priority to requester 0
// when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_pick
  import alu_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |req_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_id = req_valid[0] ? REQ0 : REQ1;
`else
  // On a tie the requester that did not win last time goes next.
  assign grant_id = (&req_valid) ? ~last_grant : req_valid[1];
`endif
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and returns the
// tagged result on a backpressured response channel. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
);
  state_e           state_q, state_d;
  logic             last_grant_q, owner_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic             rsp_valid_q, rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             grant_valid, grant_id, accept;

  alu_arb_pick u_pick (
    .req_valid   (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign accept = (state_q == IDLE) && grant_valid;

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q      <= IDLE;
      last_grant_q <= REQ1;
      owner_q      <= REQ0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= REQ0;
      rsp_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_op_q     <= (grant_id == REQ1) ? req1_op : req0_op;
        alu_a_q      <= (grant_id == REQ1) ? req1_a  : req0_a;
        alu_b_q      <= (grant_id == REQ1) ? req1_b  : req0_b;
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
      end
      // The ALU has settled on the registered operands by the end of EXEC.
      if (state_q == EXEC) begin
        rsp_data_q  <= alu_result;
        rsp_id_q    <= owner_q;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready) rsp_valid_q <= 1'b0;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU (op 11 -> a ^ b).
module tb_alu_arbiter;
  logic        clock = 1'b0;
  logic        clear;
  logic [1:0]  req_valid, req_ready;
  logic [1:0]  req0_op, req1_op, alu_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_id;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  alu_arbiter #(.WIDTH(16), .OPW(2)) dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always_comb begin
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = ~alu_a;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
    tick(); tick();
    clear = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%0b exp=0", rsp_id); end
    checks++; if ({alu_op, alu_a, alu_b} !== 34'h0) begin failures++; $display("FAIL reset_alu got=%0d/%h/%h exp=0/0/0", alu_op, alu_a, alu_b); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    tick();
  endtask

  task automatic test_add();
    req0_op = 2'b00; req0_a = 16'd805; req0_b = 16'd302; req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL add_req_ready got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00; #1;
    checks++; if (alu_op !== 2'b00 || alu_a !== 16'd805 || alu_b !== 16'd302) begin failures++; $display("FAIL add_alu_regs got=%0d/%0d/%0d exp=0/805/302", alu_op, alu_a, alu_b); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL add_exec got v=%0b rdy=%b exp v=0 rdy=00", rsp_valid, req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h0453) begin failures++; $display("FAIL add_rsp got v=%0b id=%0b d=%h exp v=1 id=0 d=0453", rsp_valid, rsp_id, rsp_data); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_done got v=%0b exp=0", rsp_valid); end
    checks++; if (alu_a !== 16'd805) begin failures++; $display("FAIL add_alu_hold got=%0d exp=805", alu_a); end
  endtask

  task automatic test_sub_not();
    req1_op = 2'b01; req1_a = 16'd805; req1_b = 16'd302; req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL sub_req_ready got=%b exp=10", req_ready); end
    tick(); req_valid = 2'b00; tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'd503) begin failures++; $display("FAIL sub_rsp got v=%0b id=%0b d=%0d exp v=1 id=1 d=503", rsp_valid, rsp_id, rsp_data); end
    tick();
    req0_op = 2'b10; req0_a = 16'd302; req0_b = 16'd0; req_valid = 2'b01;
    tick(); req_valid = 2'b00; tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'b1111111011010001) begin failures++; $display("FAIL not_rsp got v=%0b id=%0b d=%h exp v=1 id=0 d=fed1", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_arbitration();
    logic [1:0]  exp_rdy;
    logic        exp_id;
    logic [15:0] exp_d;
    do_clear();
    req0_op = 2'b00; req0_a = 16'd1;  req0_b = 16'd2;
    req1_op = 2'b01; req1_a = 16'd10; req1_b = 16'd4;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = i[0];
`endif
      exp_rdy = exp_id ? 2'b10 : 2'b01;
      exp_d   = exp_id ? 16'd6 : 16'd3;
      #1;
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL arb_grant[%0d] got=%b exp=%b", i, req_ready, exp_rdy); end
      tick(); tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_d) begin failures++; $display("FAIL arb_rsp[%0d] got v=%0b id=%0b d=%0d exp v=1 id=%0b d=%0d", i, rsp_valid, rsp_id, rsp_data, exp_id, exp_d); end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    do_clear();
    req0_op = 2'b00; req0_a = 16'd100; req0_b = 16'd23;
    req1_op = 2'b01; req1_a = 16'd50;  req1_b = 16'd8;
    req_valid = 2'b01; rsp_ready = 1'b0;
    tick(); req_valid = 2'b10; tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd123 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%0b d=%0d id=%0b rdy=%b exp v=1 d=123 id=0 rdy=00", i, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin failures++; $display("FAIL bp_release got v=%0b rdy=%b exp v=0 rdy=10", rsp_valid, req_ready); end
    tick(); req_valid = 2'b00; tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'd42) begin failures++; $display("FAIL bp_next got v=%0b id=%0b d=%0d exp v=1 id=1 d=42", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_clear_exec();
    int seen;
    req0_op = 2'b00; req0_a = 16'd7; req0_b = 16'd8; req_valid = 2'b01; rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00; clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || alu_a !== 16'h0) begin failures++; $display("FAIL clr_state got v=%0b d=%h a=%h exp v=0 d=0000 a=0000", rsp_valid, rsp_data, alu_a); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL clr_no_rsp got=%0d exp=0", seen); end
    req1_op = 2'b00; req1_a = 16'd1; req1_b = 16'd1;
    req_valid = 2'b11; #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL clr_first_grant got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00; tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'd15) begin failures++; $display("FAIL clr_after_rsp got v=%0b id=%0b d=%0d exp v=1 id=0 d=15", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_rsvd_op();
    req1_op = 2'b11; req1_a = 16'hFFFF; req1_b = 16'h0001; req_valid = 2'b10; rsp_ready = 1'b1;
    tick(); req_valid = 2'b00; #1;
    checks++; if (alu_op !== 2'b11 || alu_a !== 16'hFFFF || alu_b !== 16'h0001) begin failures++; $display("FAIL rsvd_alu got=%b/%h/%h exp=11/ffff/0001", alu_op, alu_a, alu_b); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'hFFFE) begin failures++; $display("FAIL rsvd_rsp got v=%0b id=%0b d=%h exp v=1 id=1 d=fffe", rsp_valid, rsp_id, rsp_data); end
    tick(); tick();
    checks++; if (alu_op !== 2'b11 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rsvd_idle_hold got op=%b v=%0b exp op=11 v=0", alu_op, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_not();
    test_arbitration();
    test_backpressure();
    test_clear_exec();
    test_rsvd_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 16-bit ALU (2-bit opcode: 00 add, 01 sub, 10 bitwise NOT of A, 11 reserved) between two requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the shared ALU's operand and opcode inputs from registers.
- Captures the ALU result and returns it, tagged with the requester ID, on a response channel with backpressure.
- Sits between the instruction-issue logic and the single ALU instance.

Parameters:
- WIDTH, 16, operand/result width.
- OPW, 2, opcode width.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  reset, synchronous, active-high.
- req_valid  input  2  per-requester request valid (bit i = requester i).
- req_ready  output  2  per-requester accept; at most one bit high.
- req0_op  input  OPW  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_op  input  OPW  requester 1 opcode.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- alu_op  output  OPW  to shared ALU opcode.
- alu_a  output  WIDTH  to shared ALU input A.
- alu_b  output  WIDTH  to shared ALU input B.
- alu_result  input  WIDTH  from shared ALU result (combinational).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  ID of requester owning the response.
- rsp_data  output  WIDTH  captured ALU result.

Behaviour:
- Single clock `clock`; `clear` is synchronous and active-high. On a `clock` edge with `clear`=1:
  - state=IDLE; rsp_valid=0, rsp_data=0, rsp_id=0.
  - alu_op/alu_a/alu_b registers=0.
  - last_grant=1, so requester 0 wins first.
- A transaction in flight when `clear` is asserted is dropped, and no response is produced.
- State machine:
  - IDLE: req_ready is combinational, only in IDLE. The winner gets req_ready[w]=1 when req_valid[w]=1; otherwise req_ready=0.
    - Arbitration: if only one request is valid, it wins. If both are valid, the requester other than last_grant wins (round-robin).
    - On handshake: latch winner's op/a/b into the alu_* registers, owner<=w, last_grant<=w, go to EXEC.
  - EXEC (1 cycle): alu_* are stable from registers. At the edge: rsp_data<=alu_result, rsp_id<=owner, rsp_valid<=1, go to RESP.
  - RESP: rsp_valid, rsp_data and rsp_id hold stable until rsp_valid&rsp_ready. On that edge, rsp_valid<=0 and the state goes to IDLE. rsp_ready=1 on the first RESP cycle completes it that cycle.
- Latency and throughput:
  - Response is visible 2 cycles after the accepting edge.
  - Minimum 3 cycles per operation; no new accept in EXEC or RESP (req_ready=0).
- alu_* outputs keep the last operation's values in IDLE; they change only on accept or clear.
- Opcode 11 is forwarded unchanged; the arbiter never interprets opcodes.
- A requester deasserting req_valid without a handshake is legal; nothing is latched.
- Data is a pure pass-through: no width extension or truncation, and sub results wrap modulo 2^WIDTH.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins on a simultaneous request. last_grant is not used for arbitration; it is still updated.
- Undefined: round-robin as described above.

Decomposition:
- Package alu_arb_pkg holds:
  - State enum IDLE/EXEC/RESP.
  - Opcode constants ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01, ALU_OP_NOT=2'b10, ALU_OP_RSVD=2'b11.
  - Requester ID constants REQ0=1'b0, REQ1=1'b1.
- One sub-module, alu_arb_pick: 2-way picker with inputs req_valid[1:0] and last_grant, and outputs grant_valid and grant_id. It contains the ALU_ARB_FIXED_PRIO_EN switch.
- Bench instantiates the existing ALU on the alu_* ports.

Test Plan:
- Req0 op=00, a=805, b=302, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=1107 (16'h0453); back in IDLE the next cycle.
- Req1 op=01, a=805, b=302 -> rsp_id=1, rsp_data=503. Then req0 op=10, a=302 -> rsp_data=16'b1111111011010001.
- Both valid every cycle after reset (default build) -> grants 0,1,0,1 and rsp_id alternates. With ALU_ARB_FIXED_PRIO_EN -> grants 0,0,0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id are stable, req_ready=0 throughout, and the pending req1 is accepted only after the response handshake.
- clear asserted during EXEC -> next cycle state IDLE, rsp_valid=0, rsp_data=0, no response for the dropped operation, and req0 wins the next simultaneous request.
- Opcode 11 with a=16'hFFFF, b=1 -> alu_op=2'b11 is driven for the EXEC cycle and rsp_data equals the ALU output sampled at the EXEC edge.
